// File: rtl/dog_extrema_detector.sv
`default_nettype none
// ============================================================================
// Module   : dog_extrema_detector
// Purpose  : Streaming WIN x WIN strict local max/min detector for DoG pixels.
// Revision : 1.0 - initial release
// ============================================================================
module dog_extrema_detector #(
  parameter int PIX_W      = 8,
  parameter int FRAME_W    = 200,
  parameter int FRAME_H    = 200,
  parameter int WIN        = 3,
  parameter int SIGNED_PIX = 1,
  parameter int THRESH     = 0,
  parameter int CNT_W      = 16
) (
  input  logic             pixClk,
  input  logic             rst,
  input  logic             sof,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  output logic             out_is_max,
  output logic             out_is_min,
  output logic [PIX_W-1:0] out_pix,
  output logic [15:0]      out_x,
  output logic [15:0]      out_y,
  output logic             frame_done,
  output logic [CNT_W-1:0] kp_count
);

  localparam int             c_R        = WIN / 2;
  localparam int             c_XW       = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [15:0]    c_LAST_X   = 16'(FRAME_W - 1);
  localparam logic [15:0]    c_LAST_Y   = 16'(FRAME_H - 1);
  localparam logic [15:0]    c_FIRST    = 16'(2 * c_R);
  localparam logic [15:0]    c_RW       = 16'(c_R);
  localparam logic [31:0]    c_THRESH   = 32'(THRESH);
  localparam logic [PIX_W:0] c_MAXPOS   = {2'b00, {(PIX_W-1){1'b1}}};
  localparam logic [PIX_W-1:0] c_CODE_MAX  = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0] c_CODE_MIN  = {PIX_W{1'b0}};
  localparam logic [PIX_W-1:0] c_CODE_NONE = {1'b1, {(PIX_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [CNT_W-1:0]  r_run;
  logic [PIX_W-1:0]  r_lb  [WIN-1][FRAME_W];
  logic [PIX_W-1:0]  r_win [WIN][WIN-1];

  logic [15:0]       w_cx;
  logic [15:0]       w_cy;
  logic [15:0]       w_nx;
  logic [15:0]       w_ny;
  logic [c_XW-1:0]   w_xi;
  logic              w_valid;
  logic              w_last;
  logic [PIX_W-1:0]  w_col [WIN];
  logic [PIX_W-1:0]  w_win [WIN][WIN];
  logic signed [PIX_W:0] w_cv;
  logic signed [PIX_W:0] w_nv;
  logic [PIX_W:0]    w_abs_raw;
  logic [PIX_W:0]    w_abs;
  logic              w_gt;
  logic              w_lt;
  logic              w_pass;
  logic              w_max;
  logic              w_min;
  logic              w_hit;
  logic [CNT_W-1:0]  w_run_base;
  logic [CNT_W-1:0]  w_run_inc;

  function automatic logic signed [PIX_W:0] ext(input logic [PIX_W-1:0] p);
    if (SIGNED_PIX != 0) ext = $signed({p[PIX_W-1], p});
    else                 ext = $signed({1'b0, p});
  endfunction

  // sof restarts the frame on the very pixel that carries it
  always_comb begin
    w_cx    = sof ? 16'd0 : r_x;
    w_cy    = sof ? 16'd0 : r_y;
    w_nx    = (w_cx == c_LAST_X) ? 16'd0 : w_cx + 16'd1;
    w_ny    = (w_cx != c_LAST_X) ? w_cy :
              ((w_cy == c_LAST_Y) ? 16'd0 : w_cy + 16'd1);
    w_xi    = w_cx[c_XW-1:0];
    w_valid = (w_cx >= c_FIRST) && (w_cy >= c_FIRST);
    w_last  = (w_cx == c_LAST_X) && (w_cy == c_LAST_Y);
  end

  // Row r holds line y-r, column c holds pixel x-c; centre is [R][R]
  always_comb begin
    w_col[0] = in_pix;
    for (int k = 1; k < WIN; k++) w_col[k] = r_lb[k-1][w_xi];
    for (int r = 0; r < WIN; r++) begin
      w_win[r][0] = w_col[r];
      for (int c = 1; c < WIN; c++) w_win[r][c] = r_win[r][c-1];
    end
  end

  always_comb begin
    w_cv = ext(w_win[c_R][c_R]);
    w_nv = '0;
    w_gt = 1'b1;
    w_lt = 1'b1;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if ((r != c_R) || (c != c_R)) begin
          w_nv = ext(w_win[r][c]);
          if (!(w_cv > w_nv)) w_gt = 1'b0;
          if (!(w_cv < w_nv)) w_lt = 1'b0;
        end
      end
    end
    // Negating the most negative code overflows into bit PIX_W-1; clamp it
    w_abs_raw = w_cv[PIX_W] ? $unsigned(-w_cv) : $unsigned(w_cv);
    w_abs     = (w_cv[PIX_W] && w_abs_raw[PIX_W-1]) ? c_MAXPOS : w_abs_raw;
    w_pass    = 32'(w_abs) > c_THRESH;
    w_max     = w_gt && w_pass;
    w_min     = w_lt && w_pass;
    w_hit     = w_valid && (w_max || w_min);
    w_run_base = sof ? '0 : r_run;
    w_run_inc  = (w_hit && (w_run_base != c_CNT_MAX)) ? w_run_base + CNT_W'(1)
                                                      : w_run_base;
  end

  always_ff @(posedge pixClk) begin
    if (in_valid) begin
      r_lb[0][w_xi] <= in_pix;
      for (int k = 1; k < WIN-1; k++) r_lb[k][w_xi] <= r_lb[k-1][w_xi];
      for (int r = 0; r < WIN; r++) begin
        r_win[r][0] <= w_col[r];
        for (int c = 1; c < WIN-1; c++) r_win[r][c] <= r_win[r][c-1];
      end
    end
  end

  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_run      <= '0;
      out_valid  <= 1'b0;
      out_is_max <= 1'b0;
      out_is_min <= 1'b0;
      out_pix    <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
      kp_count   <= '0;
    end else if (in_valid) begin
      r_x        <= w_nx;
      r_y        <= w_ny;
      out_valid  <= w_valid;
      out_is_max <= w_valid && w_max;
      out_is_min <= w_valid && w_min;
      frame_done <= w_valid && w_last;
      if (w_valid) begin
        out_x   <= w_cx - c_RW;
        out_y   <= w_cy - c_RW;
        out_pix <= w_max ? c_CODE_MAX : (w_min ? c_CODE_MIN : c_CODE_NONE);
      end
      if (w_valid && w_last) begin
        kp_count <= w_run_inc;
        r_run    <= '0;
      end else begin
        r_run    <= w_run_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dog_extrema_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_dog_extrema_detector
// Purpose  : Scoreboard bench driving three detector configurations at once.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dog_extrema_detector;

  localparam int c_W = 16;
  localparam int c_H = 12;
  localparam int c_N = 3;

  typedef struct {
    bit [2:0]       v, mx, mn, fd;
    bit [2:0][7:0]  pix;
    bit [2:0][15:0] x, y, kp;
  } exp_t;

  logic pixClk = 1'b0;
  logic rst;
  logic sof;
  logic in_valid;
  logic [7:0] in_pix;

  logic [2:0]       ov, omx, omn, ofd;
  logic [2:0][7:0]  opix;
  logic [2:0][15:0] ox, oy, okp;
  logic [1:0]       kp0;
  logic [15:0]      kp1, kp2;

  assign okp[0] = {14'b0, kp0};
  assign okp[1] = kp1;
  assign okp[2] = kp2;

  always #5 pixClk = ~pixClk;

  // d0: 3x3 unsigned thr 10, 2-bit count; d1: 3x3 signed thr 10; d2: 5x5 signed thr 0
  dog_extrema_detector #(.PIX_W(8), .FRAME_W(c_W), .FRAME_H(c_H), .WIN(3),
    .SIGNED_PIX(0), .THRESH(10), .CNT_W(2)) u_d0 (
    .pixClk(pixClk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_pix(in_pix),
    .out_valid(ov[0]), .out_is_max(omx[0]), .out_is_min(omn[0]), .out_pix(opix[0]),
    .out_x(ox[0]), .out_y(oy[0]), .frame_done(ofd[0]), .kp_count(kp0));

  dog_extrema_detector #(.PIX_W(8), .FRAME_W(c_W), .FRAME_H(c_H), .WIN(3),
    .SIGNED_PIX(1), .THRESH(10), .CNT_W(16)) u_d1 (
    .pixClk(pixClk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_pix(in_pix),
    .out_valid(ov[1]), .out_is_max(omx[1]), .out_is_min(omn[1]), .out_pix(opix[1]),
    .out_x(ox[1]), .out_y(oy[1]), .frame_done(ofd[1]), .kp_count(kp1));

  dog_extrema_detector #(.PIX_W(8), .FRAME_W(c_W), .FRAME_H(c_H), .WIN(5),
    .SIGNED_PIX(1), .THRESH(0), .CNT_W(16)) u_d2 (
    .pixClk(pixClk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_pix(in_pix),
    .out_valid(ov[2]), .out_is_max(omx[2]), .out_is_min(omn[2]), .out_pix(opix[2]),
    .out_x(ox[2]), .out_y(oy[2]), .frame_done(ofd[2]), .kp_count(kp2));

  int   img     [c_H][c_W];
  int   rnd_img [c_H][c_W];
  int   run     [c_N];
  int   kpm     [c_N];
  int   nov     [c_N];
  int   mx_, my_;
  int   n_cmp, n_bad;
  exp_t q [$];
  exp_t last_e;

  function automatic int cfg_win(int d);  return (d == 2) ? 5 : 3;       endfunction
  function automatic bit cfg_sgn(int d);  return d != 0;                 endfunction
  function automatic int cfg_th(int d);   return (d == 2) ? 0 : 10;      endfunction
  function automatic int cfg_cmax(int d); return (d == 0) ? 3 : 65535;   endfunction
  function automatic int sval(int p, bit s); return (s && p >= 128) ? p - 256 : p; endfunction

  function automatic int pixel(int kind, int x, int y);
    case (kind)
      0: begin
        if (x == 1 && y == 1) return 100;
        if ((x == 2 && y == 2) || (x == 5 && y == 4)) return 120;
        return 20;
      end
      1: begin
        if ((x == 5 || x == 6) && y == 4) return 200;
        if (x == 11 && y == 3) return 8;
        if (x == 11 && y == 8) return 11;
        return 0;
      end
      2: return (x == 7 && y == 6) ? 156 : 253;
      default: return rnd_img[y][x];
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mx_ = 0;
    my_ = 0;
    for (int d = 0; d < c_N; d++) begin
      run[d] = 0;
      kpm[d] = 0;
      nov[d] = 0;
    end
    last_e = '{default: '0};
  endtask

  task automatic model_push(input bit s, input int p);
    exp_t e;
    int   r, c, n, a, cx, cy;
    bit   gt, lt, pass;
    e = '{default: '0};
    if (s) begin
      mx_ = 0;
      my_ = 0;
      for (int d = 0; d < c_N; d++) run[d] = 0;
    end
    img[my_][mx_] = p;
    for (int d = 0; d < c_N; d++) begin
      r = cfg_win(d) / 2;
      if (mx_ >= 2 * r && my_ >= 2 * r) begin
        cx = mx_ - r;
        cy = my_ - r;
        c  = sval(img[cy][cx], cfg_sgn(d));
        gt = 1'b1;
        lt = 1'b1;
        for (int dy = -r; dy <= r; dy++) begin
          for (int dx = -r; dx <= r; dx++) begin
            if (dy != 0 || dx != 0) begin
              n = sval(img[cy+dy][cx+dx], cfg_sgn(d));
              if (c <= n) gt = 1'b0;
              if (c >= n) lt = 1'b0;
            end
          end
        end
        a    = (c < 0) ? ((c == -128) ? 127 : -c) : c;
        pass = a > cfg_th(d);
        e.v[d]   = 1'b1;
        e.mx[d]  = gt && pass;
        e.mn[d]  = lt && pass;
        e.pix[d] = e.mx[d] ? 8'hFF : (e.mn[d] ? 8'h00 : 8'h80);
        e.x[d]   = 16'(cx);
        e.y[d]   = 16'(cy);
        if ((gt || lt) && pass && run[d] < cfg_cmax(d)) run[d]++;
        if (mx_ == c_W - 1 && my_ == c_H - 1) begin
          e.fd[d] = 1'b1;
          kpm[d]  = run[d];
          run[d]  = 0;
        end
      end
      e.kp[d] = 16'(kpm[d]);
    end
    if (mx_ == c_W - 1) begin
      mx_ = 0;
      my_ = (my_ == c_H - 1) ? 0 : my_ + 1;
    end else begin
      mx_ = mx_ + 1;
    end
    q.push_back(e);
  endtask

  task automatic compare_out(input exp_t e);
    for (int d = 0; d < c_N; d++) begin
      check_val($sformatf("d%0d out_valid", d),  32'(ov[d]),  32'(e.v[d]));
      check_val($sformatf("d%0d is_max", d),     32'(omx[d]), 32'(e.mx[d]));
      check_val($sformatf("d%0d is_min", d),     32'(omn[d]), 32'(e.mn[d]));
      check_val($sformatf("d%0d frame_done", d), 32'(ofd[d]), 32'(e.fd[d]));
      check_val($sformatf("d%0d kp_count", d),   32'(okp[d]), 32'(e.kp[d]));
      if (e.v[d]) begin
        check_val($sformatf("d%0d out_pix", d), 32'(opix[d]), 32'(e.pix[d]));
        check_val($sformatf("d%0d out_x", d),   32'(ox[d]),   32'(e.x[d]));
        check_val($sformatf("d%0d out_y", d),   32'(oy[d]),   32'(e.y[d]));
      end
    end
  endtask

  task automatic reset_checks();
    for (int d = 0; d < c_N; d++) begin
      check_val($sformatf("d%0d rst out_valid", d),  32'(ov[d]),   0);
      check_val($sformatf("d%0d rst is_max", d),     32'(omx[d]),  0);
      check_val($sformatf("d%0d rst is_min", d),     32'(omn[d]),  0);
      check_val($sformatf("d%0d rst frame_done", d), 32'(ofd[d]),  0);
      check_val($sformatf("d%0d rst kp_count", d),   32'(okp[d]),  0);
      check_val($sformatf("d%0d rst out_pix", d),    32'(opix[d]), 0);
      check_val($sformatf("d%0d rst out_x", d),      32'(ox[d]),   0);
      check_val($sformatf("d%0d rst out_y", d),      32'(oy[d]),   0);
    end
  endtask

  task automatic accept(input bit s, input int p);
    exp_t e;
    int   r;
    @(negedge pixClk);
    sof      = s;
    in_valid = 1'b1;
    in_pix   = 8'(p);
    model_push(s, p);
    @(posedge pixClk);
    #1;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: queue empty on accepted pixel");
    end else begin
      e = q.pop_front();
      compare_out(e);
      for (int d = 0; d < c_N; d++) begin
        if (s) nov[d] = 0;
        if (ov[d] === 1'b1) nov[d]++;
        if (e.fd[d]) begin
          r = cfg_win(d) / 2;
          check_val($sformatf("d%0d valid count", d), 32'(nov[d]),
                    32'((c_W - 2 * r) * (c_H - 2 * r)));
          nov[d] = 0;
        end
      end
      last_e = e;
    end
  endtask

  task automatic idle();
    @(negedge pixClk);
    in_valid = 1'b0;
    sof      = 1'b0;
    in_pix   = 8'($urandom);
    @(posedge pixClk);
    #1;
    compare_out(last_e);
  endtask

  task automatic send_frame(input int kind, input int duty, input int npix);
    for (int i = 0; i < npix; i++) begin
      while (duty < 100 && $urandom_range(0, 99) >= duty) idle();
      accept(i == 0, pixel(kind, i % c_W, i / c_W));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    sof      = 1'b0;
    in_valid = 1'b0;
    in_pix   = '0;
    for (int y = 0; y < c_H; y++)
      for (int x = 0; x < c_W; x++) rnd_img[y][x] = $urandom_range(0, 255);
    model_reset();
    repeat (2) @(posedge pixClk);
    #1;
    reset_checks();
    @(negedge pixClk);
    rst = 1'b0;

    send_frame(0, 100, c_W * c_H);
    check_val("d0 kp peaks frame", 32'(okp[0]), 2);
    check_val("d2 kp border frame", 32'(okp[2]), 2);
    send_frame(1, 100, c_W * c_H);
    check_val("d0 kp tie/threshold frame", 32'(okp[0]), 1);
    send_frame(2, 100, c_W * c_H);
    check_val("d1 kp signed min frame", 32'(okp[1]), 1);
    check_val("d2 kp signed min frame", 32'(okp[2]), 1);
    send_frame(3, 100, c_W * c_H);
    send_frame(3, 30, c_W * c_H);

    send_frame(0, 100, 50);
    #2;
    in_valid = 1'b0;
    sof      = 1'b0;
    rst      = 1'b1;
    #1;
    reset_checks();
    model_reset();
    @(negedge pixClk);
    rst = 1'b0;
    idle();
    send_frame(0, 100, c_W * c_H);

    send_frame(3, 100, 40);
    send_frame(0, 100, c_W * c_H);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
